// File: rtl/spi_regbank_pkg.sv
// Shared types and command-field helpers for the SPI register bank.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    S_WAIT_HI,
    S_IDLE,
    S_CMD,
    S_DATA
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;

  function automatic int cmd_width(input int aw);
    return aw + 2;
  endfunction

  function automatic int cmd_rw_bit(input int aw);
    return aw + 1;
  endfunction

  function automatic int cmd_inc_bit(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/spi_regbank_burst_edge.sv
// Sample/shift edge pulses derived from the oversampled SCLK
// and the mode latched at frame start.
module spi_sclk_edge_det
  import spi_regbank_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_sclk,
  input  logic [1:0] i_mode,
  output logic       o_sample,
  output logic       o_shift
);

  logic  r_sclk_d;
  logic  w_rise;
  logic  w_fall;
  logic  w_late;
  mode_t w_mode;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_d <= 1'b0;
    end else if (i_ena) begin
      r_sclk_d <= i_sclk;
    end
  end

  assign w_mode   = mode_t'(i_mode);
  assign w_rise   = i_sclk & ~r_sclk_d;
  assign w_fall   = ~i_sclk & r_sclk_d;
  assign w_late   = w_mode.cpol ^ w_mode.cpha;
  assign o_sample = w_late ? w_fall : w_rise;
  assign o_shift  = w_late ? w_rise : w_fall;

endmodule

// File: rtl/spi_regbank_burst.sv
// SPI slave register bank: config (r/w) and status (r/o) words,
// all SPI modes, bursts with optional address auto-increment.
module spi_regbank_burst
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 16,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 6,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic                            spi_miso_oe,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            wr_strobe,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic                            wr_err,
  output logic                            frame_err
);

  localparam int CMD_W = cmd_width(ADDR_WIDTH);
  localparam int RW_B  = cmd_rw_bit(ADDR_WIDTH);
  localparam int INC_B = cmd_inc_bit(ADDR_WIDTH);
  localparam int SR_W  = (CMD_W > REG_WIDTH) ? CMD_W : REG_WIDTH;
  localparam int BC_W  = $clog2(SR_W + 1);
  localparam int TOTAL = NUM_CFG + NUM_STATUS;
  localparam logic [ADDR_WIDTH-1:0] L_LAST =
    ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH:0] L_NCFG =
    (ADDR_WIDTH + 1)'(NUM_CFG);
  localparam logic [BC_W-1:0] L_CMD_END =
    BC_W'(CMD_W - 1);
  localparam logic [BC_W-1:0] L_WORD_END =
    BC_W'(REG_WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]                   r_mode;
  logic [BC_W-1:0]              r_bitcnt;
  logic [SR_W-1:0]              r_sr;
  logic [REG_WIDTH-1:0]         r_tx;
  logic                         r_rw;
  logic                         r_inc;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic                         r_cmd_done;
  logic                         r_word_done;
  logic                         r_miso;
  logic [NUM_CFG*REG_WIDTH-1:0] r_cfg;
  logic                         r_wr_strobe;
  logic [ADDR_WIDTH-1:0]        r_wr_addr;
  logic                         r_wr_err;
  logic                         r_frame_err;

  logic                  w_sample;
  logic                  w_shift;
  logic                  w_active;
  logic                  w_cfg_hit;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH-1:0] w_fa;
  logic [REG_WIDTH-1:0]  w_rd;

  spi_sclk_edge_det u_edge (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_ena    (ena),
    .i_sclk   (spi_clk),
    .i_mode   (r_mode),
    .o_sample (w_sample),
    .o_shift  (w_shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT_HI;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // cs_n high overrides any coincident sample edge
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_WAIT_HI: if (spi_cs_n) w_state_nxt = S_IDLE;
      S_IDLE:    if (!spi_cs_n) w_state_nxt = S_CMD;
      S_CMD: begin
        if (spi_cs_n) begin
          w_state_nxt = S_IDLE;
        end else if (w_sample && r_bitcnt == L_CMD_END) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA:    if (spi_cs_n) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_active = 1'b0;
    unique case (r_state)
      S_CMD, S_DATA: w_active = 1'b1;
      default:       w_active = 1'b0;
    endcase
  end

  always_comb begin
    w_addr_nxt = r_addr;
    if (r_inc) begin
      w_addr_nxt = (r_addr == L_LAST) ? '0 : r_addr + 1'b1;
    end
  end

  assign w_fa      = r_cmd_done ? r_sr[ADDR_WIDTH-1:0] : w_addr_nxt;
  assign w_cfg_hit = {1'b0, r_addr} < L_NCFG;
  assign w_we      = r_word_done & r_rw & w_cfg_hit;

  // unmapped addresses fall through to zero
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (w_fa == ADDR_WIDTH'(k)) begin
        w_rd = r_cfg[k*REG_WIDTH +: REG_WIDTH];
      end
    end
    for (int k = 0; k < NUM_STATUS; k++) begin
      if (w_fa == ADDR_WIDTH'(NUM_CFG + k)) begin
        w_rd = status_regs[k*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= '0;
      r_bitcnt    <= '0;
      r_sr        <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_inc       <= 1'b0;
      r_addr      <= '0;
      r_cmd_done  <= 1'b0;
      r_word_done <= 1'b0;
      r_miso      <= 1'b0;
      r_cfg       <= CFG_RESET;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_err    <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (ena) begin
      r_wr_strobe <= 1'b0;
      r_wr_err    <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_word_done <= 1'b0;
      if (r_state == S_IDLE && !spi_cs_n) begin
        r_mode   <= mode;
        r_bitcnt <= '0;
      end
      if (w_active) begin
        if (spi_cs_n) begin
          r_frame_err <= (r_bitcnt != '0);
          r_bitcnt    <= '0;
        end else if (w_sample) begin
          r_sr <= {r_sr[SR_W-2:0], spi_mosi};
          if (r_state == S_CMD && r_bitcnt == L_CMD_END) begin
            r_bitcnt   <= '0;
            r_cmd_done <= 1'b1;
          end else if (r_state == S_DATA
                       && r_bitcnt == L_WORD_END) begin
            r_bitcnt    <= '0;
            r_word_done <= 1'b1;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
      end
      if (r_state != S_DATA) begin
        r_miso <= 1'b0;
      end else if (w_shift && !spi_cs_n && !r_rw) begin
        r_miso <= r_tx[REG_WIDTH-1];
        r_tx   <= {r_tx[REG_WIDTH-2:0], 1'b0};
      end
      if (r_cmd_done) begin
        r_rw   <= r_sr[RW_B];
        r_inc  <= r_sr[INC_B];
        r_addr <= r_sr[ADDR_WIDTH-1:0];
        r_tx   <= w_rd;
      end
      if (r_word_done) begin
        if (r_rw && w_cfg_hit) begin
          r_wr_strobe <= 1'b1;
          r_wr_addr   <= r_addr;
        end else if (r_rw) begin
          r_wr_err <= 1'b1;
        end
        r_addr <= w_addr_nxt;
        r_tx   <= w_rd;
      end
      for (int k = 0; k < NUM_CFG; k++) begin
        if (w_we && r_addr == ADDR_WIDTH'(k)) begin
          r_cfg[k*REG_WIDTH +: REG_WIDTH] <= r_sr[REG_WIDTH-1:0];
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = w_active;
  assign config_regs = r_cfg;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign wr_err      = r_wr_err;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Scoreboard bench for spi_regbank_burst: an SPI master drives frames,
// a protocol monitor pops expected writes/errors/read words.
module tb_spi_regbank_burst;

  localparam int H = 4;
  localparam int EV_WR = 0;
  localparam int EV_WERR = 1;
  localparam int EV_FERR = 2;
  localparam int EV_RD = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [1:0]   mode;
  logic         spi_cs_n;
  logic         spi_clk;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic [127:0] config_regs;
  logic [63:0]  status_regs;
  logic         wr_strobe;
  logic [5:0]   wr_addr;
  logic         wr_err;
  logic         frame_err;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t          exp_q[$];
  bit           tx_bits[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_cfg;
  logic [1:0]   cur_mode;

  logic         m_pcs;
  logic         m_psclk;
  logic         m_armed;
  int           m_cnt;
  logic [7:0]   m_cmd;
  logic [7:0]   m_word;

  spi_regbank_burst dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mode        (mode),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .config_regs (config_regs),
    .status_regs (status_regs),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_err      (wr_err),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] a,
                      input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    if (k == EV_WR) exp_cfg[int'(a)*8 +: 8] = d;
  endtask

  task automatic take(input int k, input logic [7:0] a,
                      input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h want none",
               k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d
          || (k == EV_WR && e.addr !== a)) begin
        n_err++;
        $display("FAIL event: got kind %0d addr %0h data %0h want kind %0d addr %0h data %0h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
  endtask

  task automatic send_bits();
    bit b;
    while (tx_bits.size() > 0) begin
      b = tx_bits.pop_front();
      if (!cur_mode[0]) begin
        spi_mosi = b;
        ticks(H);
        spi_clk = ~spi_clk;
        ticks(H);
        spi_clk = ~spi_clk;
      end else begin
        spi_clk = ~spi_clk;
        spi_mosi = b;
        ticks(H);
        spi_clk = ~spi_clk;
        ticks(H);
      end
    end
  endtask

  task automatic begin_frame(input logic [1:0] m);
    mode = m;
    cur_mode = m;
    spi_clk = m[1];
    ticks(4);
    spi_cs_n = 1'b0;
    ticks(4);
  endtask

  task automatic end_frame();
    ticks(H);
    spi_cs_n = 1'b1;
    ticks(8);
  endtask

  // Protocol monitor: decodes frames off the wires and checks strobes
  initial begin
    m_pcs = 1'b1;
    m_psclk = 1'b0;
    m_armed = 1'b0;
    m_cnt = 0;
    m_cmd = '0;
    m_word = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_armed = 1'b0;
      end else begin
        if (m_pcs && !spi_cs_n) begin
          m_armed = 1'b1;
          m_cnt = 0;
        end
        if (spi_cs_n) m_armed = 1'b0;
        if (m_armed && spi_clk != m_psclk
            && spi_clk == ~(cur_mode[1] ^ cur_mode[0])) begin
          if (m_cnt < 8) begin
            m_cmd = {m_cmd[6:0], spi_mosi};
          end else begin
            m_word = {m_word[6:0], spi_miso};
            if ((m_cnt - 8) % 8 == 7 && !m_cmd[7])
              take(EV_RD, 8'h00, m_word);
          end
          m_cnt++;
        end
        if (wr_strobe)
          take(EV_WR, {2'b00, wr_addr},
               config_regs[int'(wr_addr)*8 +: 8]);
        if (wr_err) take(EV_WERR, 8'h00, 8'h00);
        if (frame_err) take(EV_FERR, 8'h00, 8'h00);
      end
      m_pcs = spi_cs_n;
      m_psclk = spi_clk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    mode = 2'd0;
    cur_mode = 2'd0;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    status_regs = {8'h7E, 8'h66, 8'h55, 8'h44,
                   8'h33, 8'h22, 8'h10, 8'hCA};
    exp_cfg = '0;
    ticks(3);
    rst = 1'b0;
    ticks(2);
    chk("rst_cfg", config_regs, 128'h0);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_oe", spi_miso_oe, 1'b0);
    chk("rst_strobes", {wr_strobe, wr_err, frame_err}, 3'b000);
    chk("rst_wr_addr", wr_addr, 6'd0);

    // mode 0 single write
    begin_frame(2'd0);
    add_byte(8'h83);
    add_byte(8'h5A);
    push(EV_WR, 8'd3, 8'h5A);
    send_bits();
    end_frame();
    chk("t1_cfg3", config_regs[31:24], 8'h5A);

    // mode 3 incrementing burst write
    begin_frame(2'd3);
    add_byte(8'hC0);
    add_byte(8'h11);
    add_byte(8'h22);
    add_byte(8'h33);
    push(EV_WR, 8'd0, 8'h11);
    push(EV_WR, 8'd1, 8'h22);
    push(EV_WR, 8'd2, 8'h33);
    send_bits();
    end_frame();
    chk("t2_cfg", config_regs, exp_cfg);

    // mode 1: seed cfg15, then reads crossing cfg->status and wrap
    begin_frame(2'd1);
    add_byte(8'h8F);
    add_byte(8'hA5);
    push(EV_WR, 8'd15, 8'hA5);
    send_bits();
    end_frame();
    begin_frame(2'd1);
    add_byte(8'h4F);
    add_byte(8'h00);
    add_byte(8'h00);
    push(EV_RD, 8'd15, 8'hA5);
    push(EV_RD, 8'd16, 8'hCA);
    send_bits();
    end_frame();
    begin_frame(2'd1);
    add_byte(8'h57);
    add_byte(8'h00);
    add_byte(8'h00);
    push(EV_RD, 8'd23, 8'h7E);
    push(EV_RD, 8'd0, 8'h11);
    send_bits();
    end_frame();

    // mode 2: write to status address is dropped
    begin_frame(2'd2);
    add_byte(8'h90);
    add_byte(8'hFF);
    push(EV_WERR, 8'h00, 8'h00);
    send_bits();
    end_frame();
    chk("t4_cfg", config_regs, exp_cfg);

    // mode 2: fixed-address burst
    begin_frame(2'd2);
    add_byte(8'h85);
    add_byte(8'h01);
    add_byte(8'h02);
    push(EV_WR, 8'd5, 8'h01);
    push(EV_WR, 8'd5, 8'h02);
    send_bits();
    end_frame();
    chk("t4b_cfg", config_regs, exp_cfg);

    // truncated word then a clean frame
    begin_frame(2'd0);
    add_byte(8'h81);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    push(EV_FERR, 8'h00, 8'h00);
    send_bits();
    end_frame();
    chk("t5_cfg_kept", config_regs, exp_cfg);
    begin_frame(2'd0);
    add_byte(8'h81);
    add_byte(8'h3C);
    push(EV_WR, 8'd1, 8'h3C);
    send_bits();
    end_frame();
    chk("t5_cfg", config_regs, exp_cfg);

    // reset mid-frame with cs_n held low
    begin_frame(2'd0);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b0);
    send_bits();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(2);
    exp_cfg = '0;
    chk("t6_rst_cfg", config_regs, exp_cfg);
    chk("t6_rst_miso", spi_miso, 1'b0);
    chk("t6_rst_oe", spi_miso_oe, 1'b0);
    add_byte(8'h84);
    add_byte(8'h99);
    send_bits();
    ticks(4);
    chk("t6_ignored", config_regs, exp_cfg);
    spi_cs_n = 1'b1;
    ticks(8);
    begin_frame(2'd0);
    add_byte(8'h84);
    add_byte(8'h99);
    push(EV_WR, 8'd4, 8'h99);
    send_bits();
    end_frame();
    chk("t6_cfg", config_regs, exp_cfg);

    ticks(20);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
